// File: rtl/cla4_seq_pkg.sv
// rtl/cla4_seq_pkg.sv - shared state encoding and nibble sizing for the serial CLA adder
package cla4_seq_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int NIB_W = 4;

   function automatic int nib_count(input int width);
      return width / NIB_W;
   endfunction

endpackage

// File: rtl/cla4_serial_add_ctrl_if.sv
// rtl/cla4_serial_add_ctrl_if.sv - requester handshake bundle; CLA4_SEQ_SUB_EN adds the op bit
interface cla4_serial_add_ctrl_if #(
   parameter int WIDTH = 32
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             ci;
`ifdef CLA4_SEQ_SUB_EN
   logic             op;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             co;

`ifdef CLA4_SEQ_SUB_EN
   modport master (output start, a, b, ci, op, input busy, done, s, co);
   modport slave  (input start, a, b, ci, op, output busy, done, s, co);
`else
   modport master (output start, a, b, ci, input busy, done, s, co);
   modport slave  (input start, a, b, ci, output busy, done, s, co);
`endif

endinterface

// File: rtl/cla4.sv
// rtl/cla4.sv - 4-bit carry-lookahead adder slice
module cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);

   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = a & b;
   assign p = a ^ b;

   // Every carry is expanded from ci so no ripple path exists inside the slice.
   assign c[0] = ci;
   assign c[1] = g[0] | (p[0] & ci);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & ci);

   assign s  = p ^ c[3:0];
   assign co = c[4];

endmodule

// File: rtl/cla4_serial_add_ctrl.sv
// rtl/cla4_serial_add_ctrl.sv - nibble-serial WIDTH-bit adder over one cla4; CLA4_SEQ_SUB_EN adds subtract
module cla4_serial_add_ctrl
   import cla4_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset_n,
   cla4_serial_add_ctrl_if.slave  bus
);

   localparam int NIBS  = nib_count(WIDTH);
   localparam int CNT_W = $clog2(NIBS);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   s_q;
   logic               carry;
   logic               co_q;
   logic               busy_q;
   logic               done_q;
`ifdef CLA4_SEQ_SUB_EN
   logic               op_q;
`endif

   logic [NIB_W-1:0]   a_nib;
   logic [NIB_W-1:0]   b_nib;
   logic [NIB_W-1:0]   sum_nib;
   logic               sum_co;

   // Constant-index mux keeps the nibble select free of variable part-selects.
   always_comb begin
      a_nib = '0;
      b_nib = '0;
      for (int i = 0; i < NIBS; i++) begin
         if (cnt == CNT_W'(i)) begin
            a_nib = a_q[i*NIB_W +: NIB_W];
            b_nib = b_q[i*NIB_W +: NIB_W];
         end
      end
`ifdef CLA4_SEQ_SUB_EN
      b_nib = b_nib ^ {NIB_W{op_q}};
`endif
   end

   cla4 u_cla4 (
      .a  (a_nib),
      .b  (b_nib),
      .ci (carry),
      .s  (sum_nib),
      .co (sum_co)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         cnt    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         s_q    <= '0;
         carry  <= 1'b0;
         co_q   <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
`ifdef CLA4_SEQ_SUB_EN
         op_q   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  a_q    <= bus.a;
                  b_q    <= bus.b;
                  s_q    <= '0;
                  co_q   <= 1'b0;
                  cnt    <= '0;
                  busy_q <= 1'b1;
                  state  <= RUN;
`ifdef CLA4_SEQ_SUB_EN
                  op_q   <= bus.op;
                  carry  <= bus.op ? 1'b1 : bus.ci;
`else
                  carry  <= bus.ci;
`endif
               end
            end
            RUN: begin
               for (int i = 0; i < NIBS; i++) begin
                  if (cnt == CNT_W'(i)) s_q[i*NIB_W +: NIB_W] <= sum_nib;
               end
               carry <= sum_co;
               cnt   <= cnt + 1'b1;
               if (cnt == CNT_W'(NIBS - 1)) begin
                  co_q   <= sum_co;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  cnt    <= '0;
                  state  <= DONE;
               end
            end
            DONE: begin
               done_q <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.s    = s_q;
   assign bus.co   = co_q;

endmodule
